// File: rtl/nn_pkg.sv
// Shared types and constants for the output-layer score path.
package nn_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int ACC_W       = 32;
    localparam int OUT_W       = 16;
    localparam int FRAC_SHIFT  = 8;

    typedef logic [OUT_W-1:0] score_t;
    typedef score_t [NUM_CLASSES-1:0] score_arr_t;

    typedef enum logic {
        FILL   = 1'b0,
        COMMIT = 1'b1
    } collector_state_t;

endpackage

// File: rtl/neural_score_collector_if.sv
// Accumulator-to-collector stream: valid/ready handshake plus frame abort.
interface neural_score_collector_if #(
    parameter int ACC_W = nn_pkg::ACC_W
);
    logic                    acc_valid;
    logic signed [ACC_W-1:0] acc_data;
    logic                    acc_ready;
    logic                    frame_abort;

    modport master (output acc_valid, output acc_data, output frame_abort, input acc_ready);
    modport slave  (input acc_valid, input acc_data, input frame_abort, output acc_ready);
endinterface

// File: rtl/score_saturate.sv
// ReLU, arithmetic rescale and unsigned saturation of one accumulator value.
module score_saturate #(
    parameter int ACC_W      = nn_pkg::ACC_W,
    parameter int OUT_W      = nn_pkg::OUT_W,
    parameter int FRAC_SHIFT = nn_pkg::FRAC_SHIFT
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [OUT_W-1:0] score,
    output logic                    sat
);

    // Returns {sat, score}; negative inputs clamp to zero without flagging.
    function automatic logic [OUT_W:0] relu_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> FRAC_SHIFT;
        if (a < 0)
            return '0;
        if (|s[ACC_W-1:OUT_W])
            return {1'b1, {OUT_W{1'b1}}};
        return {1'b0, s[OUT_W-1:0]};
    endfunction

    // Pure combinational conversion, applied at capture time by the caller.
    always_comb begin
        {sat, score} = relu_sat(acc);
    end

endmodule

// File: rtl/neural_score_collector.sv
// Collects per-class scores serially into a fill bank and publishes whole
// frames atomically, so the downstream decoder never sees a partial frame.
module neural_score_collector #(
    parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
    parameter int ACC_W       = nn_pkg::ACC_W,
    parameter int OUT_W       = nn_pkg::OUT_W,
    parameter int FRAC_SHIFT  = nn_pkg::FRAC_SHIFT
) (
    input  logic                                clk,
    input  logic                                rst,
    neural_score_collector_if.slave             acc_if,
    output logic [NUM_CLASSES-1:0][OUT_W-1:0]   neural_out,
    output logic                                frame_valid,
    output logic                                sat_flag,
    output logic [7:0]                          frame_count
);
    import nn_pkg::*;

    localparam int IDX_W = $clog2(NUM_CLASSES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    collector_state_t                      state;
    collector_state_t                      state_nxt;
    logic [IDX_W-1:0]                      idx;
    logic [NUM_CLASSES-1:0][OUT_W-1:0]     fill_score;
    logic [NUM_CLASSES-1:0]                fill_sat;
    logic [OUT_W-1:0]                      conv_score;
    logic                                  conv_sat;
    logic                                  in_fill;
    logic                                  commit;
    logic                                  take;

    score_saturate #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_score_saturate (
        .acc   (acc_if.acc_data),
        .score (conv_score),
        .sat   (conv_sat)
    );

    // Abort outranks a coincident sample; the sample is simply dropped.
    assign take = acc_if.acc_valid && in_fill && !acc_if.frame_abort;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FILL;
        else
            state <= state_nxt;
    end

    // Next state: last accepted class enters a single COMMIT cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (take && idx == LAST_IDX) state_nxt = COMMIT;
            COMMIT:  state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // State-decoded controls; ready depends on state only.
    always_comb begin
        in_fill          = (state == FILL);
        commit           = (state == COMMIT);
        acc_if.acc_ready = in_fill;
    end

    // Fill bank: converted scores land in slot idx; abort rewinds the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            fill_score <= '0;
            fill_sat   <= '0;
        end else if (in_fill) begin
            if (acc_if.frame_abort) begin
                idx      <= '0;
                fill_sat <= '0;
            end else if (take) begin
                fill_score[idx] <= conv_score;
                fill_sat[idx]   <= conv_sat;
                idx             <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Published bank: updated only by COMMIT, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neural_out  <= '0;
            sat_flag    <= 1'b0;
            frame_count <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= commit;
            if (commit) begin
                neural_out  <= fill_score;
                sat_flag    <= |fill_sat;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_neural_score_collector.sv
// Randomized bench for neural_score_collector with a frame-level reference model.
module tb_neural_score_collector;

    logic              clk;
    logic              rst;
    logic [9:0][15:0]  neural_out;
    logic              frame_valid;
    logic              sat_flag;
    logic [7:0]        frame_count;

    neural_score_collector_if #(.ACC_W(32)) acc_if ();

    neural_score_collector dut (
        .clk         (clk),
        .rst         (rst),
        .acc_if      (acc_if.slave),
        .neural_out  (neural_out),
        .frame_valid (frame_valid),
        .sat_flag    (sat_flag),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: accepted scores of the open frame, a pending frame
    // awaiting its commit cycle, and the currently published frame.
    logic [15:0]      part_q[$];
    bit               part_sat;
    logic [9:0][15:0] pend_out;
    bit               pend_sat;
    bit               pending;
    logic [9:0][15:0] mdl_out;
    bit               mdl_sat;
    int               mdl_count;
    bit               mdl_fv;
    bit               exp_ready, obs_ready, obs_fv;

    function automatic longint scaled(input logic [31:0] d);
        longint v;
        v = longint'($signed(d));
        if (v < 0) return 0;
        return v / 256;
    endfunction

    task automatic model_reset();
        part_q.delete();
        part_sat  = 0;
        pend_out  = '0;
        pend_sat  = 0;
        pending   = 0;
        mdl_out   = '0;
        mdl_sat   = 0;
        mdl_count = 0;
        mdl_fv    = 0;
    endtask

    // One clock cycle: drive at posedge+1, sample ready mid-cycle, advance model.
    task automatic step(input bit v, input logic [31:0] d, input bit ab);
        longint raw;
        acc_if.acc_valid   = v;
        acc_if.acc_data    = d;
        acc_if.frame_abort = ab;
        exp_ready = !pending;
        #3 obs_ready = acc_if.acc_ready;
        @(posedge clk);
        if (pending) begin
            mdl_out   = pend_out;
            mdl_sat   = pend_sat;
            mdl_count = (mdl_count + 1) % 256;
            pending   = 0;
            mdl_fv    = 1;
        end else begin
            mdl_fv = 0;
            if (ab) begin
                part_q.delete();
                part_sat = 0;
            end else if (v) begin
                raw = scaled(d);
                if (raw > 65535) begin
                    part_q.push_back(16'hFFFF);
                    part_sat = 1;
                end else begin
                    part_q.push_back(16'(raw));
                end
                if (part_q.size() == 10) begin
                    for (int i = 0; i < 10; i++) pend_out[i] = part_q[i];
                    pend_sat = part_sat;
                    pending  = 1;
                    part_q.delete();
                    part_sat = 0;
                end
            end
        end
        #1 obs_fv = frame_valid;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        acc_if.acc_valid   = 1'b0;
        acc_if.acc_data    = '0;
        acc_if.frame_abort = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_assert++;
        if (neural_out !== '0) begin
            n_fail++; $display("FAIL reset_neural_out got=%h exp=0", neural_out);
        end
        n_assert++;
        if ({frame_valid, sat_flag, frame_count} !== 10'd0) begin
            n_fail++; $display("FAIL reset_flags got fv=%b sat=%b cnt=%0d exp all 0", frame_valid, sat_flag, frame_count);
        end
        n_assert++;
        if (acc_if.acc_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=1", acc_if.acc_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0]      vals [10];
        logic [15:0]      expv [10];
        int               fv_cnt = 0;
        int               nrdy = 0;
        vals = '{32'h0007F200, 32'h0001BB00, 32'h0000BF00, 32'h0001D700, 32'h00006500,
                 32'h00020800, 32'h00001A00, 32'h00003700, 32'h00001F00, 32'h00001700};
        expv = '{16'h07F2, 16'h01BB, 16'h00BF, 16'h01D7, 16'h0065,
                 16'h0208, 16'h001A, 16'h0037, 16'h001F, 16'h0017};
        for (int i = 0; i < 12; i++) begin
            if (i < 10) step(1, vals[i], 0); else step(0, 32'h0, 0);
            n_assert++;
            if (obs_ready !== exp_ready) begin
                n_fail++; $display("FAIL basic_ready cyc=%0d got=%b exp=%b", i, obs_ready, exp_ready);
            end
            if (!obs_ready) nrdy++;
            if (obs_fv) fv_cnt++;
        end
        n_assert++;
        if (nrdy != 1) begin
            n_fail++; $display("FAIL basic_ready_low_cycles got=%0d exp=1", nrdy);
        end
        n_assert++;
        if (fv_cnt != 1) begin
            n_fail++; $display("FAIL basic_fv_pulses got=%0d exp=1", fv_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            n_assert++;
            if (neural_out[i] !== expv[i]) begin
                n_fail++; $display("FAIL basic_score[%0d] got=%h exp=%h", i, neural_out[i], expv[i]);
            end
        end
        n_assert++;
        if (frame_count !== 8'd1 || sat_flag !== 1'b0) begin
            n_fail++; $display("FAIL basic_count_sat got cnt=%0d sat=%b exp cnt=1 sat=0", frame_count, sat_flag);
        end
    endtask

    task automatic test_saturate();
        logic [31:0] d;
        for (int i = 0; i < 12; i++) begin
            if (i == 3)      d = 32'hFFFFFF00;
            else if (i == 4) d = 32'h01000000;
            else if (i < 10) d = $urandom_range(0, 32'h00FFFFFF);
            else             d = 32'h0;
            step(i < 10, d, 0);
            n_assert++;
            if (obs_fv !== mdl_fv) begin
                n_fail++; $display("FAIL sat_fv cyc=%0d got=%b exp=%b", i, obs_fv, mdl_fv);
            end
        end
        n_assert++;
        if (neural_out !== mdl_out) begin
            n_fail++; $display("FAIL sat_frame got=%h exp=%h", neural_out, mdl_out);
        end
        n_assert++;
        if (neural_out[3] !== 16'h0000 || neural_out[4] !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_slots got [3]=%h [4]=%h exp 0000/FFFF", neural_out[3], neural_out[4]);
        end
        n_assert++;
        if (sat_flag !== 1'b1) begin
            n_fail++; $display("FAIL sat_flag got=%b exp=1", sat_flag);
        end
    endtask

    task automatic test_abort();
        int          fv_cnt = 0;
        logic [7:0]  cnt0;
        cnt0 = frame_count;
        for (int i = 0; i < 4; i++) step(1, $urandom, 0);
        step(1, $urandom, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 0);
            if (obs_fv) fv_cnt++;
        end
        n_assert++;
        if (fv_cnt != 0) begin
            n_fail++; $display("FAIL abort_no_fv got=%0d pulses exp=0", fv_cnt);
        end
        for (int i = 0; i < 12; i++) begin
            step(i < 10, 32'h00000100, 0);
            if (obs_fv) fv_cnt++;
        end
        n_assert++;
        if (fv_cnt != 1) begin
            n_fail++; $display("FAIL abort_fv_pulses got=%0d exp=1", fv_cnt);
        end
        n_assert++;
        if (neural_out !== {10{16'h0001}}) begin
            n_fail++; $display("FAIL abort_frame got=%h exp=all 0001", neural_out);
        end
        n_assert++;
        if (frame_count !== cnt0 + 8'd1) begin
            n_fail++; $display("FAIL abort_count got=%0d exp=%0d", frame_count, cnt0 + 8'd1);
        end
    endtask

    task automatic test_back_to_back();
        int          k = 0;
        int          fv_cnt = 0;
        int          base;
        logic [31:0] d;
        base = $urandom_range(1, 200);
        for (int c = 0; c < 25; c++) begin
            d = 32'((base + k) * 32'h00000731);
            step(1, d, 0);
            n_assert++;
            if (obs_ready !== exp_ready) begin
                n_fail++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", c, obs_ready, exp_ready);
            end
            if (obs_ready) k++;
            if (obs_fv) begin
                fv_cnt++;
                n_assert++;
                if (neural_out !== mdl_out || sat_flag !== mdl_sat) begin
                    n_fail++; $display("FAIL b2b_frame%0d got=%h sat=%b exp=%h sat=%b", fv_cnt, neural_out, sat_flag, mdl_out, mdl_sat);
                end
            end
        end
        n_assert++;
        if (fv_cnt != 2) begin
            n_fail++; $display("FAIL b2b_frames got=%0d exp=2", fv_cnt);
        end
        n_assert++;
        if (k != 23) begin
            n_fail++; $display("FAIL b2b_accepted got=%0d exp=23", k);
        end
        n_assert++;
        if (frame_count !== 8'(mdl_count)) begin
            n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", frame_count, mdl_count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) step(1, $urandom, 0);
        acc_if.acc_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_assert++;
        if (neural_out !== '0 || frame_count !== 8'd0 || sat_flag !== 1'b0 || acc_if.acc_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_outputs got out=%h cnt=%0d sat=%b rdy=%b exp 0/0/0/1", neural_out, frame_count, sat_flag, acc_if.acc_ready);
        end
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < 12; i++) step(i < 10, $urandom_range(0, 32'h00FFFFFF), 0);
        n_assert++;
        if (frame_count !== 8'd1) begin
            n_fail++; $display("FAIL midrst_count got=%0d exp=1", frame_count);
        end
        n_assert++;
        if (neural_out !== mdl_out) begin
            n_fail++; $display("FAIL midrst_frame got=%h exp=%h", neural_out, mdl_out);
        end
    endtask

    task automatic test_wrap();
        int fv_cnt = 0;
        int bad = 0;
        do_reset();
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < 11; i++) begin
                step(i < 10, $urandom, 0);
                if (obs_fv) fv_cnt++;
                if (obs_fv !== mdl_fv) bad++;
            end
        end
        step(0, 32'h0, 0);
        if (obs_fv) fv_cnt++;
        n_assert++;
        if (bad != 0) begin
            n_fail++; $display("FAIL wrap_fv_timing got=%0d misplaced exp=0", bad);
        end
        n_assert++;
        if (fv_cnt != 256) begin
            n_fail++; $display("FAIL wrap_fv_pulses got=%0d exp=256", fv_cnt);
        end
        n_assert++;
        if (frame_count !== 8'd0) begin
            n_fail++; $display("FAIL wrap_count got=%0d exp=0", frame_count);
        end
        n_assert++;
        if (neural_out !== mdl_out || sat_flag !== mdl_sat) begin
            n_fail++; $display("FAIL wrap_last_frame got=%h sat=%b exp=%h sat=%b", neural_out, sat_flag, mdl_out, mdl_sat);
        end
    endtask

    initial begin
        rst = 1'b1;
        acc_if.acc_valid   = 1'b0;
        acc_if.acc_data    = '0;
        acc_if.frame_abort = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_saturate();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
